// File: rtl/imm_extend_arbiter.sv
// Round-robin arbiter in front of a shared immediate extract/extend datapath.
// Results leave through a single-entry registered buffer with valid/ready.
module imm_extend_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_insn,
  input  logic [2*NUM_REQ-1:0]   req_kind,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_imm,
  output logic [ID_W-1:0]        out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  typedef enum logic [1:0] {
    KIND_D  = 2'b00,  // imm9,  signed
    KIND_I  = 2'b01,  // imm12, unsigned
    KIND_CB = 2'b10,  // imm19 word offset, signed
    KIND_B  = 2'b11   // imm26 word offset, signed
  } imm_kind_t;

  // Only insn[25:0] carries immediate bits for any kind.
  function automatic logic [63:0] extend_imm(input logic [25:0] f, input logic [1:0] kind);
    logic [63:0] r;
    case (kind)
      KIND_D:  r = {{55{f[20]}}, f[20:12]};
      KIND_I:  r = {52'd0, f[21:10]};
      KIND_CB: r = {{43{f[23]}}, f[23:5], 2'b00};
      default: r = {{36{f[25]}}, f[25:0], 2'b00};
    endcase
    return r;
  endfunction

  buf_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] next_ptr;
  logic            grant_found;
  logic            can_accept;
  logic            grant;
  logic [25:0]     sel_field;
  logic [1:0]      sel_kind;
  logic [63:0]     ext_imm;

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // Reset gates the grant so no handshake can complete while it is held.
  assign grant = reset && grant_found && can_accept;

  always_comb begin
    req_ready            = '0;
    req_ready[grant_idx] = grant;
  end

  // Only the granted requester's fields reach the datapath.
  assign sel_field = req_insn[32*grant_idx +: 26];
  assign sel_kind  = req_kind[2*grant_idx +: 2];
  assign ext_imm   = extend_imm(sel_field, sel_kind);
  assign next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      out_imm <= '0;
      out_id  <= '0;
      rr_ptr  <= '0;
    end else if (grant) begin
      state   <= FULL;
      out_imm <= ext_imm;
      out_id  <= grant_idx;
      rr_ptr  <= next_ptr;
    end else if (out_ready) begin
      state   <= EMPTY;
    end
  end

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Directed bench for imm_extend_arbiter (NUM_REQ=2) with a result scoreboard.
module tb_imm_extend_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  typedef struct {
    logic [63:0]     imm;
    logic [ID_W-1:0] id;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_insn;
  logic [2*NUM_REQ-1:0]  req_kind;
  logic                  out_valid;
  logic                  out_ready;
  logic [63:0]           out_imm;
  logic [ID_W-1:0]       out_id;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  imm_extend_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_insn  (req_insn),
    .req_kind  (req_kind),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension via arithmetic right shift of a left-justified field.
  function automatic logic [63:0] ref_ext(input logic [31:0] insn, input logic [1:0] kind);
    logic signed [63:0] t;
    case (kind)
      2'b00:   t = $signed({insn[20:12], 55'd0}) >>> 55;
      2'b01:   t = 64'(insn[21:10]);
      2'b10:   t = $signed({insn[23:5], 2'b00, 43'd0}) >>> 43;
      default: t = $signed({insn[25:0], 2'b00, 36'd0}) >>> 36;
    endcase
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at entry, compare at the falling edge, return 1ns after the rising edge.
  task automatic step(input string tag, input logic [1:0] rv,
                      input logic [31:0] i0, input logic [1:0] k0,
                      input logic [31:0] i1, input logic [1:0] k1,
                      input logic ordy, input logic [1:0] exp_rr, input logic exp_ov);
    exp_t e;
    req_valid = rv;
    req_insn  = {i1, i0};
    req_kind  = {k1, k0};
    out_ready = ordy;
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'(exp_rr));
    check({tag, "_valid"}, 64'(out_valid), 64'(exp_ov));
    if (out_valid === 1'b1 && sb.size() != 0 && out_ready !== 1'b1) begin
      check({tag, "_hold_imm"}, out_imm, sb[0].imm);
      check({tag, "_hold_id"}, 64'(out_id), 64'(sb[0].id));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      check({tag, "_sb_avail"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_imm"}, out_imm, e.imm);
        check({tag, "_id"}, 64'(out_id), 64'(e.id));
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) begin
        e.imm = ref_ext(req_insn[32*i +: 32], req_kind[2*i +: 2]);
        e.id  = i[ID_W-1:0];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_insn  = '0;
    req_kind  = '0;
    out_ready = 1'b0;

    // Held in reset with every requester valid.
    step("rst0", 2'b11, 32'h1234_5678, 2'b00, 32'h8765_4321, 2'b01, 1'b1, 2'b00, 1'b0);
    step("rst1", 2'b11, 32'h1234_5678, 2'b00, 32'h8765_4321, 2'b01, 1'b1, 2'b00, 1'b0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_id", 64'(out_id), 64'd0);

    // First grant after release goes to requester 0; then kind extraction on requester 0.
    reset = 1'b1;
    step("kd", 2'b11, 32'hA01F_FABC, 2'b00, 32'h0000_0C00, 2'b01, 1'b1, 2'b01, 1'b0);
    check("kd_lit", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("kd_id", 64'(out_id), 64'd0);
    step("ki", 2'b01, 32'h003F_FC00, 2'b01, 32'hxxxx_xxxx, 2'bxx, 1'b1, 2'b01, 1'b1);
    check("ki_lit", out_imm, 64'h0000_0000_0000_0FFF);
    step("kcb", 2'b01, 32'h0080_0000, 2'b10, 32'hxxxx_xxxx, 2'bxx, 1'b1, 2'b01, 1'b1);
    check("kcb_lit", out_imm, 64'hFFFF_FFFF_FFF0_0000);
    step("kb", 2'b01, 32'h0000_0001, 2'b11, 32'hxxxx_xxxx, 2'bxx, 1'b1, 2'b01, 1'b1);
    check("kb_lit", out_imm, 64'h0000_0000_0000_0004);

    // Drain to empty: valid for one more cycle, then low.
    step("drain0", 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 1'b1, 2'b00, 1'b1);
    step("drain1", 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0);

    // Round robin at full rate: pointer sits at 1 here.
    step("rr0", 2'b11, $urandom, 2'b00, $urandom, 2'b11, 1'b1, 2'b10, 1'b0);
    step("rr1", 2'b11, $urandom, 2'b10, $urandom, 2'b01, 1'b1, 2'b01, 1'b1);
    step("rr2", 2'b11, $urandom, 2'b11, $urandom, 2'b00, 1'b1, 2'b10, 1'b1);
    step("rr3", 2'b11, $urandom, 2'b00, $urandom, 2'b10, 1'b1, 2'b01, 1'b1);

    // Backpressure for five cycles, then drain and reload in the same cycle.
    for (int c = 0; c < 5; c++)
      step($sformatf("bp%0d", c), 2'b11, $urandom, 2'b01, $urandom, 2'b11, 1'b0, 2'b00, 1'b1);
    step("bprel", 2'b11, $urandom, 2'b10, $urandom, 2'b11, 1'b1, 2'b10, 1'b1);
    step("bpend0", 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 1'b1, 2'b00, 1'b1);
    step("bpend1", 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0);

    // Reset while a result is stalled in the buffer.
    step("mr0", 2'b10, $urandom, 2'b00, 32'hFFFF_FFFF, 2'b00, 1'b0, 2'b10, 1'b0);
    step("mr1", 2'b11, $urandom, 2'b01, $urandom, 2'b01, 1'b0, 2'b00, 1'b1);
    reset = 1'b0;
    #1;
    check("mr_async_valid", 64'(out_valid), 64'd0);
    check("mr_async_ready", 64'(req_ready), 64'd0);
    check("mr_async_imm", out_imm, 64'd0);
    sb.delete();
    step("mr_hold", 2'b11, $urandom, 2'b00, $urandom, 2'b00, 1'b1, 2'b00, 1'b0);
    reset = 1'b1;
    step("mr_rel", 2'b11, 32'h0010_0000, 2'b00, $urandom, 2'b11, 1'b1, 2'b01, 1'b0);
    check("mr_rel_imm", out_imm, 64'hFFFF_FFFF_FFFF_FF00);
    step("mr_pop", 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 1'b1, 2'b00, 1'b1);
    step("mr_end", 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
